mult_sched: RTL and testbench



---
 rtl/mult_sched_if.sv | 45 ++++
 rtl/mult_sched.sv | 124 ++++++++++++
 tb/tb_mult_sched.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_sched_if.sv
// Signal bundle between the multiplier scheduler, its two requesters,
// their response consumers and the shared pipelined multiplier.
interface mult_sched_if #(
  parameter int N = 4,
  parameter int M = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [N-1:0]     req0_a;
  logic [M-1:0]     req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [N-1:0]     req1_a;
  logic [M-1:0]     req1_b;

  logic             pipe_en;
  logic [M+N-1:0]   pipe_mult1;
  logic [M-1:0]     pipe_mult2;
  logic             pipe_ready;
  logic [M+N-1:0]   pipe_result;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [M+N-1:0]   rsp0_data;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [M+N-1:0]   rsp1_data;

  logic             busy;
  logic             err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
           pipe_ready, pipe_result, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, pipe_en, pipe_mult1, pipe_mult2,
           rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy, err
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
           pipe_ready, pipe_result, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, pipe_en, pipe_mult1, pipe_mult2,
           rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy, err
  );
endinterface

// File: rtl/mult_sched.sv
// Round-robin, credit-based sharing of one fixed-latency multiplier pipeline
// between two requesters, with per-requester in-order response buffers.
module mult_sched #(
  parameter int N       = 4,
  parameter int M       = 4,
  parameter int LAT     = 4,
  parameter int CREDITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_sched_if.slave bus
);
  localparam int W  = M + N;
  localparam int PW = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CREDITS - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [1:0]     elig, gnt, rsp_hs, push, nonempty;
  logic [CW-1:0]  credit_q [2];
  logic [CW-1:0]  credit_d [2];
  logic           last_q, last_d;
  logic           pipe_en_q, pipe_id_q;
  logic [W-1:0]   mult1_q;
  logic [M-1:0]   mult2_q;
  logic [LAT-1:0] tag_v_q, tag_id_q;
  logic [W-1:0]   mem_q [2][CREDITS];
  logic [PW-1:0]  rd_q [2];
  logic [PW-1:0]  wr_q [2];
  logic [CW-1:0]  cnt_q [2];
  logic           err_q;
  logic           tail_v, tail_id;

  assign tail_v  = tag_v_q[LAT-1];
  assign tail_id = tag_id_q[LAT-1];

  // Arbitration: a tie goes to the requester that was not granted last.
  always_comb begin
    elig[0]     = bus.req0_valid && (credit_q[0] != '0);
    elig[1]     = bus.req1_valid && (credit_q[1] != '0);
    gnt         = '0;
    if (rst_n) begin
      if (elig[0] && (!elig[1] || last_q)) gnt[0] = 1'b1;
      else if (elig[1])                    gnt[1] = 1'b1;
    end
    last_d      = gnt[1] ? 1'b1 : (gnt[0] ? 1'b0 : last_q);
    nonempty[0] = (cnt_q[0] != '0);
    nonempty[1] = (cnt_q[1] != '0);
    rsp_hs[0]   = nonempty[0] && bus.rsp0_ready;
    rsp_hs[1]   = nonempty[1] && bus.rsp1_ready;
    for (int k = 0; k < 2; k++) begin
      push[k]     = tail_v && (tail_id == 1'(k));
      credit_d[k] = credit_q[k];
      if (gnt[k] && !rsp_hs[k])      credit_d[k] = credit_q[k] - 1'b1;
      else if (!gnt[k] && rsp_hs[k]) credit_d[k] = credit_q[k] + 1'b1;
    end
  end

  // Issue stage and owner tags; the tag tail lines up with pipe_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= 1'b1;
      pipe_en_q <= 1'b0;
      pipe_id_q <= 1'b0;
      mult1_q   <= '0;
      mult2_q   <= '0;
      tag_v_q   <= '0;
      tag_id_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      last_q    <= last_d;
      pipe_en_q <= |gnt;
      if (|gnt) begin
        pipe_id_q <= gnt[1];
        mult1_q   <= gnt[1] ? {{M{1'b0}}, bus.req1_a} : {{M{1'b0}}, bus.req0_a};
        mult2_q   <= gnt[1] ? bus.req1_b : bus.req0_b;
      end
      tag_v_q[0]  <= pipe_en_q;
      tag_id_q[0] <= pipe_id_q;
      for (int i = 1; i < LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
      if (bus.pipe_ready != tail_v) err_q <= 1'b1;
    end
  end

  // Response buffers and credits; credits guarantee a push never hits a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        credit_q[k] <= CW'(CREDITS);
        rd_q[k]     <= '0;
        wr_q[k]     <= '0;
        cnt_q[k]    <= '0;
        for (int i = 0; i < CREDITS; i++) mem_q[k][i] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        credit_q[k] <= credit_d[k];
        if (push[k]) begin
          mem_q[k][wr_q[k]] <= bus.pipe_result;
          wr_q[k]           <= ptr_inc(wr_q[k]);
        end
        if (rsp_hs[k]) rd_q[k] <= ptr_inc(rd_q[k]);
        cnt_q[k] <= cnt_q[k] + CW'(push[k]) - CW'(rsp_hs[k]);
      end
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.pipe_en    = pipe_en_q;
  assign bus.pipe_mult1 = mult1_q;
  assign bus.pipe_mult2 = mult2_q;
  assign bus.rsp0_valid = nonempty[0];
  assign bus.rsp1_valid = nonempty[1];
  assign bus.rsp0_data  = mem_q[0][rd_q[0]];
  assign bus.rsp1_data  = mem_q[1][rd_q[1]];
  assign bus.busy       = (|tag_v_q) || pipe_en_q || (|nonempty);
  assign bus.err        = err_q;
endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: models the shared multiplier pipeline and keeps
// per-requester expected-product queues filled from observed handshakes.
module tb_mult_sched;
  localparam int N = 4, M = 4, LAT = 4, CREDITS = 2, W = M + N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inj = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mult_sched_if #(.N(N), .M(M)) bus ();
  mult_sched #(.N(N), .M(M), .LAT(LAT), .CREDITS(CREDITS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Shared multiplier: LAT-cycle delay line, product from the issued operands.
  logic [LAT-1:0] pv;
  logic [W-1:0]   pr [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pr[i] <= '0;
    end else begin
      pv[0] <= bus.pipe_en;
      pr[0] <= bus.pipe_mult1 * W'(bus.pipe_mult2);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pr[i] <= pr[i-1];
      end
    end
  end
  assign bus.pipe_ready  = pv[LAT-1] | inj;
  assign bus.pipe_result = pr[LAT-1];

  // Reference: every accepted request owes its requester a*b, in order.
  logic [W-1:0] exp0[$], exp1[$], got0[$], got1[$];
  int           gnt_log[$];
  int           viol = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req0_valid && bus.req0_ready) begin
        exp0.push_back(W'(bus.req0_a) * W'(bus.req0_b));
        gnt_log.push_back(0);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        exp1.push_back(W'(bus.req1_a) * W'(bus.req1_b));
        gnt_log.push_back(1);
      end
      if (bus.rsp0_valid && bus.rsp0_ready) got0.push_back(bus.rsp0_data);
      if (bus.rsp1_valid && bus.rsp1_ready) got1.push_back(bus.rsp1_data);
      if (exp0.size() - got0.size() > CREDITS || exp1.size() - got1.size() > CREDITS)
        viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
    gnt_log.delete();
    viol = 0;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_a = '1; bus.req0_b = '1; bus.req1_a = '1; bus.req1_b = '1;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b, expected 00", {bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if ({bus.pipe_en, bus.pipe_mult1, bus.pipe_mult2} !== '0) begin
      errors++; $display("FAIL reset_pipe: got en=%b m1=%h m2=%h, expected all 0",
                         bus.pipe_en, bus.pipe_mult1, bus.pipe_mult2);
    end
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.rsp1_data} !== '0) begin
      errors++; $display("FAIL reset_rsp: got v=%b%b d0=%h d1=%h, expected all 0",
                         bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.rsp1_data);
    end
    checks++;
    if ({bus.busy, bus.err} !== 2'b00) begin
      errors++; $display("FAIL reset_status: got busy=%b err=%b, expected 0 0", bus.busy, bus.err);
    end
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    int           en_cyc  = -1;
    int           rsp_cyc = -1;
    logic [W-1:0] rsp_dat = '0;
    logic [W-1:0] m1 = '0;
    logic [M-1:0] m2 = '0;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd3; bus.req0_b = 4'd5;
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready: got %b, expected 1", bus.req0_ready);
    end
    for (int c = 1; c <= LAT + 4; c++) begin
      tick();
      bus.req0_valid = 1'b0;
      @(negedge clk);
      if (bus.pipe_en === 1'b1 && en_cyc < 0) begin
        en_cyc = c; m1 = bus.pipe_mult1; m2 = bus.pipe_mult2;
      end
      if (bus.rsp0_valid === 1'b1 && rsp_cyc < 0) begin
        rsp_cyc = c; rsp_dat = bus.rsp0_data;
      end
    end
    checks++;
    if (en_cyc != 1) begin
      errors++; $display("FAIL single_pipe_en_cycle: got %0d, expected 1", en_cyc);
    end
    checks++;
    if (m1 !== 8'h03 || m2 !== 4'h5) begin
      errors++; $display("FAIL single_operands: got %h/%h, expected 03/5", m1, m2);
    end
    checks++;
    if (rsp_cyc != LAT + 2) begin
      errors++; $display("FAIL single_rsp_cycle: got %0d, expected %0d", rsp_cyc, LAT + 2);
    end
    checks++;
    if (rsp_dat !== 8'd15) begin
      errors++; $display("FAIL single_rsp_data: got %0d, expected 15", rsp_dat);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_after: got %b, expected 0", bus.busy);
    end
    tick();
  endtask

  task automatic test_max_req1();
    bit           seen = 1'b0;
    bit           wrong_side = 1'b0;
    logic [W-1:0] d = '0;
    bus.req1_valid = 1'b1; bus.req1_a = 4'hF; bus.req1_b = 4'hF;
    @(negedge clk);
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++; $display("FAIL max_ready1: got %b, expected 1", bus.req1_ready);
    end
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      bus.req1_valid = 1'b0;
      @(negedge clk);
      if (bus.rsp0_valid === 1'b1) wrong_side = 1'b1;
      if (bus.rsp1_valid === 1'b1) begin
        seen = 1'b1; d = bus.rsp1_data;
      end
    end
    checks++;
    if (!seen || d !== 8'hE1) begin
      errors++; $display("FAIL max_rsp1_data: got seen=%b data=%h, expected seen=1 data=e1", seen, d);
    end
    checks++;
    if (wrong_side) begin
      errors++; $display("FAIL max_steering: got rsp0_valid=1, expected 0");
    end
    tick();
  endtask

  task automatic test_contention();
    bit ok;
    int alt_bad = 0;
    int bad0 = 0;
    int bad1 = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_log();
    bus.req0_valid = 1'b1; bus.req0_a = 4'd2; bus.req0_b = 4'd7;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd9; bus.req1_b = 4'd9;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    repeat (30) tick();
    idle_inputs();
    drain(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL contention_drain: got busy after 200 cycles, expected idle");
    end
    for (int i = 0; i < gnt_log.size(); i++) if (gnt_log[i] != i % 2) alt_bad++;
    checks++;
    if (gnt_log.size() < 8 || alt_bad != 0) begin
      errors++; $display("FAIL contention_alternation: got %0d grants with %0d out of order, expected >=8 alternating from 0",
                         gnt_log.size(), alt_bad);
    end
    foreach (got0[i]) if (got0[i] !== 8'd14) bad0++;
    foreach (got1[i]) if (got1[i] !== 8'd81) bad1++;
    checks++;
    if (got0.size() != exp0.size() || got0.size() < 3 || bad0 != 0) begin
      errors++; $display("FAIL contention_rsp0: got %0d rsp (%0d wrong), expected %0d (>=3) of 14",
                         got0.size(), bad0, exp0.size());
    end
    checks++;
    if (got1.size() != exp1.size() || got1.size() < 3 || bad1 != 0) begin
      errors++; $display("FAIL contention_rsp1: got %0d rsp (%0d wrong), expected %0d (>=3) of 81",
                         got1.size(), bad1, exp1.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int got_at_third = -1;
    int bad = 0;
    clear_log();
    bus.rsp0_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 4'hF; bus.req0_b = 4'hF;
    repeat (12) tick();
    checks++;
    if (exp0.size() != CREDITS) begin
      errors++; $display("FAIL bp_issues_stalled: got %0d, expected %0d", exp0.size(), CREDITS);
    end
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready_low: got %b, expected 0", bus.req0_ready);
    end
    tick();
    bus.rsp0_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (exp0.size() >= 3) begin
        got_at_third = got0.size();
        bus.req0_valid = 1'b0;
        break;
      end
    end
    checks++;
    if (exp0.size() != 3 || got_at_third < 1) begin
      errors++; $display("FAIL bp_third_issue: got issues=%0d rsp_before=%0d, expected 3 and >=1",
                         exp0.size(), got_at_third);
    end
    idle_inputs();
    drain(ok);
    foreach (got0[i]) if (got0[i] !== 8'd225) bad++;
    checks++;
    if (!ok || got0.size() != 3 || bad != 0) begin
      errors++; $display("FAIL bp_responses: got drained=%b n=%0d wrong=%0d, expected 1 3 0",
                         ok, got0.size(), bad);
    end
  endtask

  task automatic test_random();
    bit ok;
    int bad0 = 0;
    int bad1 = 0;
    clear_log();
    for (int c = 0; c < 400; c++) begin
      tick();
      bus.req0_valid = ($urandom_range(0, 3) != 0);
      bus.req1_valid = ($urandom_range(0, 3) != 0);
      bus.req0_a = N'($urandom); bus.req0_b = M'($urandom);
      bus.req1_a = N'($urandom); bus.req1_b = M'($urandom);
      bus.rsp0_ready = ($urandom_range(0, 2) != 0);
      bus.rsp1_ready = ($urandom_range(0, 2) != 0);
    end
    tick();
    idle_inputs();
    drain(ok);
    checks++;
    if (!ok || got0.size() != exp0.size() || got1.size() != exp1.size()) begin
      errors++; $display("FAIL random_counts: got drained=%b rsp0=%0d rsp1=%0d, expected 1 %0d %0d",
                         ok, got0.size(), got1.size(), exp0.size(), exp1.size());
    end
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) if (got0[i] !== exp0[i]) bad0++;
    for (int i = 0; i < got1.size() && i < exp1.size(); i++) if (got1[i] !== exp1[i]) bad1++;
    checks++;
    if (bad0 != 0 || bad1 != 0 || exp0.size() == 0 || exp1.size() == 0) begin
      errors++; $display("FAIL random_data: got %0d/%0d wrong of %0d/%0d, expected 0 wrong and both active",
                         bad0, bad1, exp0.size(), exp1.size());
    end
    checks++;
    if (viol != 0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL random_credit_err: got overruns=%0d err=%b, expected 0 0", viol, bus.err);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    int stale = 0;
    int bad = 0;
    clear_log();
    bus.req0_valid = 1'b1; bus.req0_a = 4'd7; bus.req0_b = 4'd3;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.pipe_en, bus.pipe_mult1, bus.pipe_mult2, bus.rsp0_valid,
         bus.rsp0_data, bus.busy, bus.err} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got rdy=%b en=%b m1=%h m2=%h v=%b d=%h busy=%b err=%b, expected all 0",
                         bus.req0_ready, bus.pipe_en, bus.pipe_mult1, bus.pipe_mult2,
                         bus.rsp0_valid, bus.rsp0_data, bus.busy, bus.err);
    end
    tick();
    tick();
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 6; c++) begin
      @(negedge clk);
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.err !== 1'b0) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL midreset_stale: got %0d cycles with rsp/err, expected 0", stale);
    end
    clear_log();
    bus.rsp0_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd2;
    repeat (10) tick();
    checks++;
    if (exp0.size() != CREDITS) begin
      errors++; $display("FAIL midreset_credits: got %0d issues, expected %0d", exp0.size(), CREDITS);
    end
    idle_inputs();
    drain(ok);
    foreach (got0[i]) if (got0[i] !== 8'd2) bad++;
    checks++;
    if (!ok || got0.size() != CREDITS || bad != 0) begin
      errors++; $display("FAIL midreset_rsp: got drained=%b n=%0d wrong=%0d, expected 1 %0d 0",
                         ok, got0.size(), bad, CREDITS);
    end
  endtask

  task automatic test_protocol_error();
    int rsp_seen = 0;
    inj = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL perr_before: got %b, expected 0", bus.err);
    end
    tick();
    inj = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++; $display("FAIL perr_set: got %b, expected 1", bus.err);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) rsp_seen++;
    end
    checks++;
    if (bus.err !== 1'b1 || rsp_seen != 0) begin
      errors++; $display("FAIL perr_sticky: got err=%b rsp_cycles=%0d, expected 1 0", bus.err, rsp_seen);
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL perr_cleared: got %b, expected 0", bus.err);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_max_req1();
    test_contention();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_protocol_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
